// File: rtl/compare_pkg.sv
// Shared definitions for the chunk-serial magnitude comparator:
// one-hot result codes and the sequencer state type.
package compare_pkg;

    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/compare_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice, one-hot result.
module compare_chunk
    import compare_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic [2:0]       res_o
);

    // Priority select of the one-hot code for this slice.
    always_comb begin
        res_o = RES_EQ;
        if (a_i > b_i) begin
            res_o = RES_GT;
        end else if (a_i < b_i) begin
            res_o = RES_LT;
        end
    end

endmodule

// File: rtl/compare_seq.sv
// compare_seq: sequential magnitude comparator. Operands are captured on
// accept and compared CHUNK bits per cycle from the MSB end, stopping at
// the first differing slice. Signed compare is done by flipping both MSBs
// at capture, which maps two's-complement order onto unsigned order.
// Optional result statistics counters are enabled by defining
// COMPARE_SEQ_STATS_EN.
//
// state | meaning
// IDLE  | ready for a request, out = 000
// RUN   | comparing slice idx, MSB-first
// DONE  | result held on out until the consumer takes it
module compare_seq
    import compare_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out
`ifdef COMPARE_SEQ_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt
`endif
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCH - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("compare_seq: WIDTH must be a multiple of CHUNK");
        end
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("compare_seq: WIDTH must be in the range 2..64");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [2:0]       out_q, out_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [2:0]       chunk_res;

    assign a_chunk = a_q[CHUNK*int'(idx_q) +: CHUNK];
    assign b_chunk = b_q[CHUNK*int'(idx_q) +: CHUNK];

    compare_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i   (a_chunk),
        .b_i   (b_chunk),
        .res_o (chunk_res)
    );

    // Sequencer state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            out_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    // Next-state: capture on accept, walk slices, hold result until taken.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
                    b_d     = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};
                    idx_d   = IDX_TOP;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (chunk_res != RES_EQ) begin
                    out_d   = chunk_res;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    out_d   = RES_EQ;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_d   = RES_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                out_d   = RES_NONE;
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;

`ifdef COMPARE_SEQ_STATS_EN
    logic [CNT_W-1:0] cnt_gt_q, cnt_eq_q, cnt_lt_q;
    logic             out_hs;

    assign out_hs = out_valid & out_ready;

    // Saturating per-result counters; clear beats a coincident handshake.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            cnt_gt_q <= '0;
            cnt_eq_q <= '0;
            cnt_lt_q <= '0;
        end else if (out_hs) begin
            if (out_q == RES_GT && cnt_gt_q != {CNT_W{1'b1}}) begin
                cnt_gt_q <= cnt_gt_q + 1'b1;
            end
            if (out_q == RES_EQ && cnt_eq_q != {CNT_W{1'b1}}) begin
                cnt_eq_q <= cnt_eq_q + 1'b1;
            end
            if (out_q == RES_LT && cnt_lt_q != {CNT_W{1'b1}}) begin
                cnt_lt_q <= cnt_lt_q + 1'b1;
            end
        end
    end

    assign cnt_gt = cnt_gt_q;
    assign cnt_eq = cnt_eq_q;
    assign cnt_lt = cnt_lt_q;
`endif

endmodule

// File: tb/tb_compare_seq.sv
// Scoreboard bench for compare_seq (WIDTH=8, CHUNK=2). The driver pushes
// the expected result and latency on each accept; a negedge monitor pops
// and compares when out_valid rises, and checks hold/idle behaviour.
// Statistics checks are compiled in with COMPARE_SEQ_STATS_EN.
module tb_compare_seq;

    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sgn = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2:0]       out;
`ifdef COMPARE_SEQ_STATS_EN
    logic             stats_clr = 1'b0;
    logic [15:0]      cnt_gt, cnt_eq, cnt_lt;
`endif

    always #5 clk = ~clk;

    compare_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef COMPARE_SEQ_STATS_EN
        ,
        .stats_clr (stats_clr),
        .cnt_gt    (cnt_gt),
        .cnt_eq    (cnt_eq),
        .cnt_lt    (cnt_lt)
`endif
    );

    typedef struct {
        logic [2:0] res;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    bit         busy = 0;
    bit         pend_rel = 0;
    bit         prev_valid = 0;
    logic [2:0] prev_out = '0;
    int         ready_mode = 2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain signed/unsigned compare; latency is the position of
    // the highest differing slice counted from the top.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit s);
        exp_t e;
        bit   found;
        if (s) begin
            if ($signed(x) > $signed(y))      e.res = 3'b100;
            else if ($signed(x) < $signed(y)) e.res = 3'b001;
            else                              e.res = 3'b010;
        end else begin
            if (x > y)      e.res = 3'b100;
            else if (x < y) e.res = 3'b001;
            else            e.res = 3'b010;
        end
        e.lat = NCH;
        found = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && x[i] != y[i]) begin
                e.lat = NCH - i / CHUNK;
                found = 1;
            end
        end
        e.acc = 0;
        return e;
    endfunction

    // Monitor: compares results against the scoreboard and picks out_ready.
    always @(negedge clk) begin
        exp_t e;
        if (pend_rel) begin
            busy     = 0;
            pend_rel = 0;
        end
        if (!rst) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !busy});
            if (out_valid) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_result: got out=%b with no request pending, expected none", out);
                    end else begin
                        e = sb.pop_front();
                        chk("result", {29'd0, out}, {29'd0, e.res});
                        chk("latency", cyc - e.acc - 1, e.lat);
                    end
                end else begin
                    chk("hold_stable", {29'd0, out}, {29'd0, prev_out});
                end
            end else begin
                chk("out_zero", {29'd0, out}, 32'd0);
            end
            prev_valid = out_valid;
            prev_out   = out;
            case (ready_mode)
                0:       out_ready = 1'b0;
                2:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) pend_rel = 1;
        end else begin
            prev_valid = 0;
            pend_rel   = 0;
            out_ready  = 1'b0;
        end
    end

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit s);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL issue_timeout: in_ready=0, expected 1 within 200 cycles");
            return;
        end
        e     = model(x, y, s);
        e.acc = cyc;
        a = x; b = y; sgn = s; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        busy     = 1;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        sgn = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((busy || sb.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (busy || sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: busy=%0d pending=%0d, expected 0/0", busy, sb.size());
        end
    endtask

    // Called just after a posedge; reset is sampled on the following edge.
    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        busy = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            checks++;
            $display("FAIL valid_timeout: out_valid=0, expected 1 within 50 cycles");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out", {29'd0, out}, 32'd0);

        // Directed vectors with an always-ready consumer.
        issue(8'hA5, 8'hA5, 1'b0); drain();
        issue(8'h80, 8'h7F, 1'b0); drain();
        issue(8'h80, 8'h7F, 1'b1); drain();
        issue(8'h34, 8'h35, 1'b0); drain();
        issue(8'h00, 8'hFF, 1'b1); drain();
        issue(8'h7F, 8'h80, 1'b1); drain();

        // Backpressure: result held, stray in_valid ignored.
        @(posedge clk); #1; ready_mode = 0;
        issue(8'hC3, 8'h3C, 1'b0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin
                in_valid = 1'b1; a = 8'h00; b = 8'hFF; sgn = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        ready_mode = 2;
        drain();

        // Reset two cycles after accept aborts the operation.
        issue(8'h01, 8'h00, 1'b0);
        @(posedge clk); #1;
        do_reset();
        repeat (8) @(negedge clk);
        issue(8'h01, 8'h00, 1'b0); drain();

        // Reset while a result waits in DONE discards it.
        @(posedge clk); #1; ready_mode = 0;
        issue(8'h10, 8'h20, 1'b0);
        wait_valid();
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("abort_done_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1; ready_mode = 2;

        // Random traffic with a random consumer.
        @(posedge clk); #1; ready_mode = 1;
        for (int n = 0; n < 150; n++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            if (n % 10 == 0) drain();
        end
        drain();
        @(posedge clk); #1; ready_mode = 2;

`ifdef COMPARE_SEQ_STATS_EN
        @(negedge clk); stats_clr = 1'b1;
        @(posedge clk); #1; stats_clr = 1'b0;
        issue(8'h05, 8'h01, 1'b0); drain();
        issue(8'hFF, 8'h00, 1'b0); drain();
        issue(8'h01, 8'hFF, 1'b1); drain();
        issue(8'h42, 8'h42, 1'b0); drain();
        issue(8'h99, 8'h99, 1'b1); drain();
        issue(8'h80, 8'h00, 1'b1); drain();
        chk("cnt_gt", {16'd0, cnt_gt}, 32'd3);
        chk("cnt_eq", {16'd0, cnt_eq}, 32'd2);
        chk("cnt_lt", {16'd0, cnt_lt}, 32'd1);
        @(negedge clk); stats_clr = 1'b1;
        @(posedge clk); #1; stats_clr = 1'b0;
        @(negedge clk);
        chk("clr_gt", {16'd0, cnt_gt}, 32'd0);
        chk("clr_eq", {16'd0, cnt_eq}, 32'd0);
        chk("clr_lt", {16'd0, cnt_lt}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
